// File: rtl/csi_rx_pixel_buffer.sv
// CSI-2 RX line buffer: admits whole lines into a show-ahead FIFO and streams them out as Avalon-ST packets.
// Optional status logic (line_drop_cnt, proto_err, clr_status) is built only when CSI_RX_PIXEL_BUFFER_STATS_EN is defined.
module csi_rx_pixel_buffer #(
    parameter int FIFO_DEPTH     = 1024,
    parameter int MAX_LINE_WORDS = 640
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   pix_data,
    input  logic                          pix_valid,
    input  logic                          pix_line_start,
    input  logic                          pix_line_end,
    output logic [31:0]                   avl_st_out_data,
    output logic                          avl_st_out_valid,
    output logic                          avl_st_out_startofpacket,
    output logic                          avl_st_out_endofpacket,
    input  logic                          avl_st_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_usedw,
    output logic [15:0]                   line_drop_cnt,
    output logic                          proto_err,
    input  logic                          clr_status,
    output logic [1:0]                    dbg_in_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = AW + 1;
    localparam int CW = $clog2(MAX_LINE_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } in_state_e;

    in_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_inc;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]     usedw_q, usedw_d;
    logic [UW-1:0]     free_words;
    logic [33:0]       mem_q [FIFO_DEPTH];
    logic [33:0]       head;
    logic              wr_en, wr_sop, wr_eop, rd_en;
    logic              drop_inc, err_set;

    // A line is admitted only if the FIFO can hold a maximum-length line,
    // so writes never need a full check.
    assign free_words = UW'(FIFO_DEPTH) - usedw_q;
    assign cnt_inc    = cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_sop   = 1'b0;
        wr_eop   = 1'b0;
        drop_inc = 1'b0;
        err_set  = 1'b0;
        if (pix_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (!pix_line_start) begin
                        err_set = 1'b1;
                    end else if (free_words >= UW'(MAX_LINE_WORDS)) begin
                        wr_en  = 1'b1;
                        wr_sop = 1'b1;
                        cnt_d  = CW'(1);
                        if (pix_line_end) begin
                            wr_eop = 1'b1;
                        end else if (MAX_LINE_WORDS == 1) begin
                            wr_eop  = 1'b1;
                            err_set = 1'b1;
                            state_d = S_DROP;
                        end else begin
                            state_d = S_PASS;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = pix_line_end ? S_IDLE : S_DROP;
                    end
                end
                S_PASS: begin
                    wr_en   = 1'b1;
                    cnt_d   = cnt_inc;
                    err_set = pix_line_start;
                    if (pix_line_end) begin
                        wr_eop  = 1'b1;
                        state_d = S_IDLE;
                    end else if (cnt_inc == CW'(MAX_LINE_WORDS)) begin
                        wr_eop  = 1'b1;
                        err_set = 1'b1;
                        state_d = S_DROP;
                    end
                end
                S_DROP: begin
                    if (pix_line_end) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Avalon-ST source: valid means the FIFO is non-empty; a word leaves on a
    // cycle with valid & ready, and data/sop/eop hold while valid & !ready.
    assign rd_en = (usedw_q != '0) && avl_st_out_ready;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en, rd_en})
            2'b10:   usedw_d = usedw_q + UW'(1);
            2'b01:   usedw_d = usedw_q - UW'(1);
            default: usedw_d = usedw_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {wr_eop, wr_sop, pix_data};
    end

    // Outputs are forced to zero while empty so reset clears them immediately.
    assign head                     = mem_q[rd_ptr_q];
    assign avl_st_out_valid         = (usedw_q != '0);
    assign avl_st_out_data          = avl_st_out_valid ? head[31:0] : 32'd0;
    assign avl_st_out_startofpacket = avl_st_out_valid & head[32];
    assign avl_st_out_endofpacket   = avl_st_out_valid & head[33];
    assign fifo_usedw               = usedw_q;
    assign dbg_in_state             = state_q;

`ifdef CSI_RX_PIXEL_BUFFER_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        proto_err_q, proto_err_d;

    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        proto_err_d = proto_err_q;
        if (clr_status) begin
            drop_cnt_d  = '0;
            proto_err_d = 1'b0;
        end else begin
            if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            if (err_set) proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign line_drop_cnt = drop_cnt_q;
    assign proto_err     = proto_err_q;
`else
    logic unused_stats;
    assign unused_stats  = ^{clr_status, drop_inc, err_set};
    assign line_drop_cnt = 16'd0;
    assign proto_err     = 1'b0;
`endif

endmodule

// File: tb/tb_csi_rx_pixel_buffer.sv
// Bench for csi_rx_pixel_buffer: directed line scenarios plus a randomized run against a queue model.
module tb_csi_rx_pixel_buffer;
    localparam int FIFO_DEPTH     = 16;
    localparam int MAX_LINE_WORDS = 8;
    localparam int UW             = $clog2(FIFO_DEPTH) + 1;
    localparam int M_IDLE = 0, M_PASS = 1, M_DROP = 2;
`ifdef CSI_RX_PIXEL_BUFFER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_line_start = 1'b0;
    logic          pix_line_end = 1'b0;
    logic [31:0]   avl_st_out_data;
    logic          avl_st_out_valid;
    logic          avl_st_out_startofpacket;
    logic          avl_st_out_endofpacket;
    logic          avl_st_out_ready = 1'b0;
    logic [UW-1:0] fifo_usedw;
    logic [15:0]   line_drop_cnt;
    logic          proto_err;
    logic          clr_status = 1'b0;
    logic [1:0]    dbg_in_state;

    int checks = 0;
    int failures = 0;

    // Reference model: the FIFO contents as {eop, sop, data}, the line mode and the status.
    logic [33:0] exp_q[$];
    int          m_mode = M_IDLE;
    int          m_cnt = 0;
    int          m_drop = 0;
    bit          m_err = 1'b0;

    typedef struct packed {
        logic        v;
        logic        s;
        logic        e;
        logic [31:0] d;
    } stim_t;

    csi_rx_pixel_buffer #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .MAX_LINE_WORDS(MAX_LINE_WORDS)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .pix_data                (pix_data),
        .pix_valid               (pix_valid),
        .pix_line_start          (pix_line_start),
        .pix_line_end            (pix_line_end),
        .avl_st_out_data         (avl_st_out_data),
        .avl_st_out_valid        (avl_st_out_valid),
        .avl_st_out_startofpacket(avl_st_out_startofpacket),
        .avl_st_out_endofpacket  (avl_st_out_endofpacket),
        .avl_st_out_ready        (avl_st_out_ready),
        .fifo_usedw              (fifo_usedw),
        .line_drop_cnt           (line_drop_cnt),
        .proto_err               (proto_err),
        .clr_status              (clr_status),
        .dbg_in_state            (dbg_in_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_drop();
        return STATS_EN ? 16'(m_drop) : 16'd0;
    endfunction

    function automatic logic exp_err();
        return STATS_EN ? m_err : 1'b0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_drop = 0;
        m_err  = 1'b0;
    endtask

    task automatic drive_idle();
        pix_valid      = 1'b0;
        pix_data       = '0;
        pix_line_start = 1'b0;
        pix_line_end   = 1'b0;
    endtask

    task automatic drive_word(input logic [31:0] d, input logic s, input logic e);
        pix_valid      = 1'b1;
        pix_data       = d;
        pix_line_start = s;
        pix_line_end   = e;
    endtask

    task automatic do_reset();
        drive_idle();
        clr_status       = 1'b0;
        avl_st_out_ready = 1'b0;
        rst_n            = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock edge; the model applies the line rules to what the DUT sampled.
    task automatic tick();
        int free;
        bit d_inc, e_set;
        @(posedge clk);
        free  = FIFO_DEPTH - exp_q.size();
        d_inc = 1'b0;
        e_set = 1'b0;
        if (avl_st_out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (pix_valid) begin
            case (m_mode)
                M_IDLE: begin
                    if (!pix_line_start) begin
                        e_set = 1'b1;
                    end else if (free >= MAX_LINE_WORDS) begin
                        exp_q.push_back({pix_line_end, 1'b1, pix_data});
                        m_cnt  = 1;
                        m_mode = pix_line_end ? M_IDLE : M_PASS;
                    end else begin
                        d_inc  = 1'b1;
                        m_mode = pix_line_end ? M_IDLE : M_DROP;
                    end
                end
                M_PASS: begin
                    m_cnt++;
                    exp_q.push_back({(pix_line_end || m_cnt == MAX_LINE_WORDS), 1'b0, pix_data});
                    if (pix_line_start) e_set = 1'b1;
                    if (pix_line_end) begin
                        m_mode = M_IDLE;
                    end else if (m_cnt == MAX_LINE_WORDS) begin
                        e_set  = 1'b1;
                        m_mode = M_DROP;
                    end
                end
                default: if (pix_line_end) m_mode = M_IDLE;
            endcase
        end
        if (clr_status) begin
            m_drop = 0;
            m_err  = 1'b0;
        end else begin
            if (d_inc && m_drop < 65535) m_drop++;
            if (e_set) m_err = 1'b1;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (avl_st_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", avl_st_out_valid); end
        checks++; if (avl_st_out_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %0h expected 0", avl_st_out_data); end
        checks++; if ({avl_st_out_startofpacket, avl_st_out_endofpacket} !== 2'b00) begin failures++; $display("FAIL reset_sop_eop: got %b expected 00", {avl_st_out_startofpacket, avl_st_out_endofpacket}); end
        checks++; if (fifo_usedw !== '0) begin failures++; $display("FAIL reset_usedw: got %0d expected 0", fifo_usedw); end
        checks++; if (line_drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt: got %0d expected 0", line_drop_cnt); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err: got %0b expected 0", proto_err); end
        do_reset();
    endtask

    task automatic test_basic_line();
        do_reset();
        avl_st_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_word(32'hA0 + i, (i == 0), (i == 3));
            tick();
            checks++;
            if (avl_st_out_valid !== 1'b1 || avl_st_out_data !== 32'hA0 + i ||
                avl_st_out_startofpacket !== (i == 0) || avl_st_out_endofpacket !== (i == 3)) begin
                failures++;
                $display("FAIL basic_word%0d: got v=%0b d=%0h sop=%0b eop=%0b expected v=1 d=%0h sop=%0b eop=%0b",
                         i, avl_st_out_valid, avl_st_out_data, avl_st_out_startofpacket,
                         avl_st_out_endofpacket, 32'hA0 + i, (i == 0), (i == 3));
            end
            checks++; if (fifo_usedw !== UW'(1)) begin failures++; $display("FAIL basic_usedw%0d: got %0d expected 1", i, fifo_usedw); end
        end
        drive_idle();
        tick();
        checks++; if (avl_st_out_valid !== 1'b0 || fifo_usedw !== '0) begin failures++; $display("FAIL basic_drained: got v=%0b usedw=%0d expected v=0 usedw=0", avl_st_out_valid, fifo_usedw); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        do_reset();
        for (int l = 0; l < 3; l++) begin
            for (int w = 0; w < 8; w++) begin
                drive_word(32'h100 * l + w, (w == 0), (w == 7));
                tick();
            end
        end
        drive_idle();
        checks++; if (fifo_usedw !== UW'(16)) begin failures++; $display("FAIL ovf_usedw: got %0d expected 16", fifo_usedw); end
        checks++; if (line_drop_cnt !== (STATS_EN ? 16'd1 : 16'd0)) begin failures++; $display("FAIL ovf_drop_cnt: got %0d expected %0d", line_drop_cnt, (STATS_EN ? 1 : 0)); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL ovf_proto_err: got %0b expected 0", proto_err); end
        avl_st_out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            d = 32'h100 * (n / 8) + (n % 8);
            checks++;
            if (avl_st_out_valid !== 1'b1 || avl_st_out_data !== d ||
                avl_st_out_startofpacket !== (n % 8 == 0) || avl_st_out_endofpacket !== (n % 8 == 7)) begin
                failures++;
                $display("FAIL ovf_drain%0d: got v=%0b d=%0h sop=%0b eop=%0b expected v=1 d=%0h sop=%0b eop=%0b",
                         n, avl_st_out_valid, avl_st_out_data, avl_st_out_startofpacket,
                         avl_st_out_endofpacket, d, (n % 8 == 0), (n % 8 == 7));
            end
            tick();
        end
        checks++; if (avl_st_out_valid !== 1'b0 || fifo_usedw !== '0) begin failures++; $display("FAIL ovf_empty: got v=%0b usedw=%0d expected v=0 usedw=0", avl_st_out_valid, fifo_usedw); end
    endtask

    // Runs straight after test_overflow so a nonzero drop count is there to clear.
    task automatic test_no_start();
        avl_st_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_word(32'hE0 + i, 1'b0, (i == 2));
            tick();
            checks++; if (avl_st_out_valid !== 1'b0 || fifo_usedw !== '0) begin failures++; $display("FAIL nostart_out%0d: got v=%0b usedw=%0d expected v=0 usedw=0", i, avl_st_out_valid, fifo_usedw); end
        end
        drive_idle();
        checks++; if (proto_err !== exp_err()) begin failures++; $display("FAIL nostart_proto_err: got %0b expected %0b", proto_err, exp_err()); end
        checks++; if (line_drop_cnt !== exp_drop()) begin failures++; $display("FAIL nostart_drop_cnt: got %0d expected %0d", line_drop_cnt, exp_drop()); end
        // clear coincides with another framing error: the clear must win
        drive_word(32'hEE, 1'b0, 1'b0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        drive_idle();
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL clr_proto_err: got %0b expected 0", proto_err); end
        checks++; if (line_drop_cnt !== 16'd0) begin failures++; $display("FAIL clr_drop_cnt: got %0d expected 0", line_drop_cnt); end
    endtask

    task automatic test_long_line();
        logic [33:0] got_q[$];
        logic [33:0] want;
        do_reset();
        avl_st_out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) drive_word(32'hB0 + i, (i == 0), (i == 9));
            else        drive_idle();
            if (avl_st_out_valid === 1'b1)
                got_q.push_back({avl_st_out_endofpacket, avl_st_out_startofpacket, avl_st_out_data});
            tick();
        end
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL long_count: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            want = {(i == 7), (i == 0), 32'hB0 + i};
            checks++; if (got_q[i] !== want) begin failures++; $display("FAIL long_word%0d: got %0h expected %0h", i, got_q[i], want); end
        end
        checks++; if (proto_err !== (STATS_EN ? 1'b1 : 1'b0)) begin failures++; $display("FAIL long_proto_err: got %0b expected %0b", proto_err, STATS_EN); end
        checks++; if (fifo_usedw !== '0) begin failures++; $display("FAIL long_usedw: got %0d expected 0", fifo_usedw); end
    endtask

    task automatic test_random();
        stim_t       stim_q[$];
        stim_t       s;
        int          n;
        int          total;
        logic [33:0] exp_head;
        do_reset();
        for (int l = 0; l < 100; l++) begin
            n = $urandom_range(1, 8);
            for (int w = 0; w < n; w++) begin
                if ($urandom_range(0, 4) == 0) stim_q.push_back('0);
                s.v = 1'b1;
                s.s = (w == 0);
                s.e = (w == n - 1);
                s.d = $urandom();
                stim_q.push_back(s);
            end
            if ($urandom_range(0, 1) == 0) stim_q.push_back('0);
        end
        total = stim_q.size() + 40;
        for (int i = 0; i < total; i++) begin
            if (i < stim_q.size()) begin
                s = stim_q[i];
                pix_valid = s.v; pix_data = s.d; pix_line_start = s.s; pix_line_end = s.e;
                avl_st_out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                drive_idle();
                avl_st_out_ready = 1'b1;
            end
            exp_head = (exp_q.size() != 0) ? exp_q[0] : 34'd0;
            checks++; if (avl_st_out_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL rand_valid@%0d: got %0b expected %0b", i, avl_st_out_valid, (exp_q.size() != 0)); end
            checks++; if ({avl_st_out_endofpacket, avl_st_out_startofpacket, avl_st_out_data} !== exp_head) begin failures++; $display("FAIL rand_head@%0d: got %0h expected %0h", i, {avl_st_out_endofpacket, avl_st_out_startofpacket, avl_st_out_data}, exp_head); end
            checks++; if (fifo_usedw !== UW'(exp_q.size())) begin failures++; $display("FAIL rand_usedw@%0d: got %0d expected %0d", i, fifo_usedw, exp_q.size()); end
            checks++; if (fifo_usedw > UW'(FIFO_DEPTH)) begin failures++; $display("FAIL rand_usedw_bound@%0d: got %0d limit %0d", i, fifo_usedw, FIFO_DEPTH); end
            checks++; if (line_drop_cnt !== exp_drop() || proto_err !== exp_err()) begin failures++; $display("FAIL rand_status@%0d: got drop=%0d err=%0b expected drop=%0d err=%0b", i, line_drop_cnt, proto_err, exp_drop(), exp_err()); end
            tick();
        end
        checks++; if (avl_st_out_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL rand_final: got v=%0b model_left=%0d expected v=0 model_left=0", avl_st_out_valid, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_word(32'hC0 + i, (i == 0), 1'b0);
            tick();
        end
        checks++; if (fifo_usedw !== UW'(5)) begin failures++; $display("FAIL mid_usedw_before: got %0d expected 5", fifo_usedw); end
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (avl_st_out_valid !== 1'b0 || avl_st_out_data !== 32'd0 || avl_st_out_startofpacket !== 1'b0 || avl_st_out_endofpacket !== 1'b0) begin failures++; $display("FAIL mid_outputs: got v=%0b d=%0h sop=%0b eop=%0b expected all 0", avl_st_out_valid, avl_st_out_data, avl_st_out_startofpacket, avl_st_out_endofpacket); end
        checks++; if (fifo_usedw !== '0) begin failures++; $display("FAIL mid_usedw: got %0d expected 0", fifo_usedw); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        avl_st_out_ready = 1'b1;
        drive_word(32'hDEAD, 1'b0, 1'b0);
        tick();
        checks++; if (avl_st_out_valid !== 1'b0) begin failures++; $display("FAIL mid_bare_word: got v=%0b expected 0", avl_st_out_valid); end
        checks++; if (proto_err !== (STATS_EN ? 1'b1 : 1'b0)) begin failures++; $display("FAIL mid_proto_err: got %0b expected %0b", proto_err, STATS_EN); end
        for (int i = 0; i < 3; i++) begin
            drive_word(32'hD0 + i, (i == 0), (i == 2));
            tick();
            checks++;
            if (avl_st_out_valid !== 1'b1 || avl_st_out_data !== 32'hD0 + i ||
                avl_st_out_startofpacket !== (i == 0) || avl_st_out_endofpacket !== (i == 2)) begin
                failures++;
                $display("FAIL mid_next_line%0d: got v=%0b d=%0h sop=%0b eop=%0b expected v=1 d=%0h sop=%0b eop=%0b",
                         i, avl_st_out_valid, avl_st_out_data, avl_st_out_startofpacket,
                         avl_st_out_endofpacket, 32'hD0 + i, (i == 0), (i == 2));
            end
        end
        drive_idle();
        tick();
        checks++; if (fifo_usedw !== '0) begin failures++; $display("FAIL mid_final_usedw: got %0d expected 0", fifo_usedw); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_line();
        test_overflow();
        test_no_start();
        test_long_line();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
